// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_if
// Purpose  : Request/response handshake and word-wide memory bus between the
//            execute stage, the memory access unit and the memory.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;

    logic [31:0] mem_address;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Environment side: issues requests and plays the memory.
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_fault,
        input  mem_address, mem_write, mem_wdata,
        output mem_rdata
    );

    // Access unit side.
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_fault,
        output mem_address, mem_write, mem_wdata,
        input  mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store initiator with ARM7 unaligned rotation, sub-word
//            read-modify-write and ROM write protection.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter logic [31:0] ROM_END     = 32'd64000
) (
    input  logic        clk,
    input  logic        reset,
    mem_access_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_WAIT = 2'd1,
        WRITE     = 2'd2,
        RMW_WRITE = 2'd3
    } state_t;

    localparam logic [3:0] c_last_count = 4'(MEM_LATENCY);

    state_t      r_state;
    logic [3:0]  r_count;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [1:0]  r_offset;
    logic [15:0] r_wdata;
    logic [31:0] r_mem_address;
    logic        r_mem_write;
    logic [31:0] r_mem_wdata;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_fault;

    logic        w_fault;
    logic        w_sub_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merge_data;

    assign w_fault    = (bus.req_write && (bus.req_addr < ROM_END)) ||
                        ((bus.req_size == 2'b01) && bus.req_addr[0]);
    assign w_sub_word = ~bus.req_size[1];

    assign w_byte = bus.mem_rdata[{r_offset, 3'b000} +: 8];
    assign w_half = bus.mem_rdata[{r_offset[1], 4'b0000} +: 16];

    always_comb begin
        w_load_data = bus.mem_rdata;
        case (r_size)
            2'b00:   w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{r_signed & w_half[15]}}, w_half};
            default: begin
                // Unaligned word loads return the rotated word, ARM7 style.
                case (r_offset)
                    2'd1:    w_load_data = {bus.mem_rdata[7:0],  bus.mem_rdata[31:8]};
                    2'd2:    w_load_data = {bus.mem_rdata[15:0], bus.mem_rdata[31:16]};
                    2'd3:    w_load_data = {bus.mem_rdata[23:0], bus.mem_rdata[31:24]};
                    default: w_load_data = bus.mem_rdata;
                endcase
            end
        endcase
    end

    always_comb begin
        w_merge_data = bus.mem_rdata;
        if (r_size == 2'b00) begin
            w_merge_data[{r_offset, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merge_data[{r_offset[1], 4'b0000} +: 16] = r_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_write       <= 1'b0;
            r_size        <= 2'b00;
            r_signed      <= 1'b0;
            r_offset      <= 2'b00;
            r_wdata       <= '0;
            r_mem_address <= '0;
            r_mem_write   <= 1'b0;
            r_mem_wdata   <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_rdata  <= '0;
            r_resp_fault  <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_mem_address <= {bus.req_addr[31:2], 2'b00};
                        r_write       <= bus.req_write;
                        r_size        <= bus.req_size;
                        r_signed      <= bus.req_signed;
                        r_offset      <= bus.req_addr[1:0];
                        r_wdata       <= bus.req_wdata[15:0];
                        r_count       <= '0;
                        if (w_fault) begin
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                            r_resp_rdata <= '0;
                        end else if (bus.req_write && !w_sub_word) begin
                            r_mem_write <= 1'b1;
                            r_mem_wdata <= bus.req_wdata;
                            r_state     <= WRITE;
                        end else begin
                            r_state <= READ_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (r_count == c_last_count) begin
                        if (r_write) begin
                            r_mem_wdata <= w_merge_data;
                            r_mem_write <= 1'b1;
                            r_state     <= RMW_WRITE;
                        end else begin
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b0;
                            r_resp_rdata <= w_load_data;
                            r_state      <= IDLE;
                        end
                    end else begin
                        r_count <= r_count + 4'd1;
                    end
                end
                WRITE, RMW_WRITE: begin
                    r_mem_write  <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_fault <= 1'b0;
                    r_resp_rdata <= '0;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready   = (r_state == IDLE);
    assign bus.mem_address = r_mem_address;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_rdata  = r_resp_rdata;
    assign bus.resp_fault  = r_resp_fault;
endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Randomised self-checking bench for mem_access_unit against a
//            cycle-indexed behavioural model, plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    localparam int          LAT       = 1;
    localparam logic [31:0] ROM_END   = 32'd64000;
    localparam int          MEM_WORDS = 65536;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_if bus();

    mem_access_unit #(.MEM_LATENCY(LAT), .ROM_END(ROM_END)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory image seen by the DUT and the model's view of what it should hold.
    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic [31:0] rd_pipe [LAT];
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rd_pipe[0] <= mem[bus.mem_address[17:2]];
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (bus.mem_write) mem[bus.mem_address[17:2]] = bus.mem_wdata;
    end
    assign bus.mem_rdata = rd_pipe[LAT-1];

    // Expected behaviour keyed by cycle index (value of cyc during that cycle).
    bit          exp_busy [int];
    logic [32:0] exp_resp [int];
    logic [31:0] exp_wr   [int];
    logic [31:0] addr_at  [int];
    int          last_exp_cyc = 0;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] load_value(input logic [31:0] word, input logic [1:0] sz,
                                               input logic sg, input int off);
        int          b [4];
        int          v;
        logic [31:0] res;
        for (int k = 0; k < 4; k++) b[k] = int'(word[8*k +: 8]);
        case (sz)
            2'b00: begin
                v = b[off];
                if (sg && v > 127) v = v - 256;
                return 32'(v);
            end
            2'b01: begin
                v = b[off] + 256 * b[off+1];
                if (sg && v > 32767) v = v - 65536;
                return 32'(v);
            end
            default: begin
                res = '0;
                for (int k = 0; k < 4; k++) res = res | (32'(b[(off + k) % 4]) << (8 * k));
                return res;
            end
        endcase
    endfunction

    task automatic predict(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd, input int n0);
        int          off;
        int          idx;
        int          rc;
        logic [31:0] word;
        bit          fault;
        off  = int'(a[1:0]);
        idx  = int'(a[17:2]);
        word = ref_mem[idx];
        addr_at[n0] = {a[31:2], 2'b00};
        fault = (wr && (a < ROM_END)) || ((sz == 2'b01) && a[0]);
        if (fault) begin
            rc = n0;
            exp_resp[rc] = {1'b1, 32'h0};
        end else if (!wr) begin
            for (int i = 0; i <= LAT; i++) exp_busy[n0 + i] = 1'b1;
            rc = n0 + LAT + 1;
            exp_resp[rc] = {1'b0, load_value(word, sz, sg, off)};
        end else if (sz[1]) begin
            exp_busy[n0] = 1'b1;
            exp_wr[n0]   = wd;
            ref_mem[idx] = wd;
            rc = n0 + 1;
            exp_resp[rc] = {1'b0, 32'h0};
        end else begin
            for (int i = 0; i <= LAT + 1; i++) exp_busy[n0 + i] = 1'b1;
            word[8*off +: 8] = wd[7:0];
            if (sz == 2'b01) word[8*(off+1) +: 8] = wd[15:8];
            exp_wr[n0 + LAT + 1] = word;
            ref_mem[idx] = word;
            rc = n0 + LAT + 2;
            exp_resp[rc] = {1'b0, 32'h0};
        end
        if (rc > last_exp_cyc) last_exp_cyc = rc;
    endtask

    // Called at a falling edge; returns at the falling edge of the cycle after acceptance.
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd, output int n0);
        bus.req_valid  = 1'b1;
        bus.req_write  = wr;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        n0 = -1;
        for (int t = 0; t < 100; t++) begin
            if (!exp_busy.exists(cyc)) begin
                n0 = cyc + 1;
                break;
            end
            @(negedge clk);
        end
        if (n0 < 0) begin
            n_total++;
            $display("FAIL accept_timeout: request at addr 0x%08h never became acceptable", a);
        end else begin
            predict(wr, sz, sg, a, wd, n0);
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        bus.req_valid = 1'b0;
        while (cyc <= last_exp_cyc) @(negedge clk);
    endtask

    // Observations of the DUT used by the directed literal checks.
    bit          chk_en = 1'b0;
    logic [31:0] cur_addr = '0;
    int          last_resp_cyc = -1;
    logic [31:0] last_rdata = '0;
    logic        last_fault = 1'b0;
    int          n_writes = 0;
    logic [31:0] last_wdata = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            int c;
            c = cyc;
            chk("req_ready", 32'(bus.req_ready), 32'(!exp_busy.exists(c)));
            if (exp_resp.exists(c)) begin
                chk("resp_valid", 32'(bus.resp_valid), 32'd1);
                chk("resp_rdata", bus.resp_rdata, exp_resp[c][31:0]);
                chk("resp_fault", 32'(bus.resp_fault), 32'(exp_resp[c][32]));
            end else begin
                chk("resp_valid_idle", 32'(bus.resp_valid), 32'd0);
            end
            if (exp_wr.exists(c)) begin
                chk("mem_write", 32'(bus.mem_write), 32'd1);
                chk("mem_wdata", bus.mem_wdata, exp_wr[c]);
            end else begin
                chk("mem_write_idle", 32'(bus.mem_write), 32'd0);
            end
            if (addr_at.exists(c)) cur_addr = addr_at[c];
            chk("mem_address", bus.mem_address, cur_addr);
            if (bus.resp_valid) begin
                last_resp_cyc = c;
                last_rdata    = bus.resp_rdata;
                last_fault    = bus.resp_fault;
            end
            if (bus.mem_write) begin
                n_writes++;
                last_wdata = bus.mem_wdata;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        int          w0;
        int          mism;
        logic [31:0] a;
        logic [31:0] orig;

        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = 32'(i) * 32'h9E37_79B9 + 32'h1234_5678;
            ref_mem[i] = mem[i];
        end
        mem[32'h1000 >> 2]  = 32'h1122_3344;  ref_mem[32'h1000 >> 2]  = 32'h1122_3344;
        mem[32'h2000 >> 2]  = 32'h0000_8000;  ref_mem[32'h2000 >> 2]  = 32'h0000_8000;
        mem[32'h10000 >> 2] = 32'hAABB_CCDD;  ref_mem[32'h10000 >> 2] = 32'hAABB_CCDD;

        reset          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        repeat (3) @(negedge clk);
        chk("rst req_ready",   32'(bus.req_ready),  32'd1);
        chk("rst mem_write",   32'(bus.mem_write),  32'd0);
        chk("rst mem_address", bus.mem_address,     32'd0);
        chk("rst mem_wdata",   bus.mem_wdata,       32'd0);
        chk("rst resp_valid",  32'(bus.resp_valid), 32'd0);
        chk("rst resp_rdata",  bus.resp_rdata,      32'd0);
        chk("rst resp_fault",  32'(bus.resp_fault), 32'd0);
        reset  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        do_req(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, n0);
        wait_idle();
        chk("tp1 rdata",   last_rdata, 32'h1122_3344);
        chk("tp1 fault",   32'(last_fault), 32'd0);
        chk("tp1 latency", 32'(last_resp_cyc - n0), 32'd2);

        do_req(1'b0, 2'b10, 1'b0, 32'h1001, 32'h0, n0);
        wait_idle();
        chk("tp2 rotate", last_rdata, 32'h4411_2233);
        do_req(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, n0);
        wait_idle();
        chk("tp2 byte", last_rdata, 32'h0000_0011);

        do_req(1'b0, 2'b01, 1'b1, 32'h2000, 32'h0, n0);
        wait_idle();
        chk("tp3 shalf", last_rdata, 32'hFFFF_8000);
        do_req(1'b0, 2'b00, 1'b1, 32'h2001, 32'h0, n0);
        wait_idle();
        chk("tp3 sbyte", last_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 2'b01, 1'b0, 32'h2001, 32'h0, n0);
        wait_idle();
        chk("tp3 misaligned fault", 32'(last_fault), 32'd1);
        chk("tp3 misaligned rdata", last_rdata, 32'd0);

        w0 = n_writes;
        do_req(1'b1, 2'b00, 1'b0, 32'h10002, 32'h55, n0);
        wait_idle();
        chk("tp4 write count", 32'(n_writes - w0), 32'd1);
        chk("tp4 merged",      last_wdata, 32'hAA55_CCDD);
        chk("tp4 latency",     32'(last_resp_cyc - n0), 32'(LAT + 2));
        do_req(1'b0, 2'b10, 1'b0, 32'h10000, 32'h0, n0);
        wait_idle();
        chk("tp4 readback", last_rdata, 32'hAA55_CCDD);

        w0 = n_writes;
        do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, n0);
        wait_idle();
        chk("tp5 write count", 32'(n_writes - w0), 32'd0);
        chk("tp5 fault",       32'(last_fault), 32'd1);
        chk("tp5 latency",     32'(last_resp_cyc - n0), 32'd0);

        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 32'hFFFF);
            else                           a = 32'h10000 + $urandom_range(0, 32'hFF);
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, $urandom, n0);
            if ($urandom_range(0, 3) == 0) begin
                bus.req_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
        wait_idle();
        mism = 0;
        for (int i = 0; i <= (32'h100FF >> 2); i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("memory image", 32'(mism), 32'd0);

        // Reset in the read phase of a byte store must abort it silently.
        chk_en = 1'b0;
        repeat (2) @(negedge clk);
        orig           = mem[32'h12000 >> 2];
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h12001;
        bus.req_wdata  = 32'h77;
        @(posedge clk);
        #1;
        chk("abort accepted", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 1'b0;
        #1;
        reset = 1'b0;
        #1;
        chk("abort req_ready", 32'(bus.req_ready), 32'd1);
        chk("abort mem_write", 32'(bus.mem_write), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort no resp",  32'(bus.resp_valid), 32'd0);
            chk("abort no write", 32'(bus.mem_write),  32'd0);
        end
        chk("abort memory", mem[32'h12000 >> 2], orig);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
